// File: rtl/fc_mac_array.sv
// fc_mac_array: NUM_LANES signed fixed-point dot-product neurons sharing one activation stream; define FC_RELU_EN to clamp negative results to zero
module fc_mac_array #(
  parameter int PREC      = 18,
  parameter int FRAC      = 14,
  parameter int FAN_IN    = 784,
  parameter int NUM_LANES = 4,
  parameter int ID_WIDTH  = 10,
  parameter int ACC_WIDTH = 40,
  parameter int BP_SHIFT  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PREC-1:0]           activation_i,
  input  logic [NUM_LANES*PREC-1:0] weight_i,
  input  logic [NUM_LANES*PREC-1:0] bias_i,
  input  logic                      bias_en_i,
  input  logic [ID_WIDTH-1:0]       neuron_id_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      clear_i,
  output logic [NUM_LANES*PREC-1:0] activation_o,
  output logic [ID_WIDTH-1:0]       neuron_id_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NUM_LANES-1:0]      sat_o,
  input  logic                      b_valid_i,
  input  logic                      bp_mode,
  output logic [NUM_LANES*PREC-1:0] b_gradient_o,
  output logic                      b_valid_o
);
  localparam int CW = FAN_IN > 1 ? $clog2(FAN_IN) : 1;
  logic [CW-1:0] cnt;
  logic first, last, acc_en;
  assign ready_o = !valid_o || ready_i;
  assign acc_en  = valid_i && ready_o && !clear_i;
  assign first   = cnt == '0;
  assign last    = cnt == CW'(FAN_IN - 1);
  // beat counter, result handshake and gradient valid delay
  always_ff @(posedge clk)
    if (!rst) begin
      cnt         <= '0;
      valid_o     <= 1'b0;
      neuron_id_o <= '0;
      b_valid_o   <= 1'b0;
    end else begin
      b_valid_o <= b_valid_i;
      if (clear_i) cnt <= '0;
      else if (acc_en) cnt <= last ? '0 : cnt + CW'(1);
      if (acc_en && last) begin
        valid_o     <= 1'b1;
        neuron_id_o <= neuron_id_i;
      end else if (ready_i) valid_o <= 1'b0;
    end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic signed [PREC-1:0] w, b;
    logic signed [2*PREC-1:0] prod, gshr;
    logic signed [ACC_WIDTH:0] base, sum;
    logic signed [ACC_WIDTH-1:0] acc, acc_sat;
    logic signed [ACC_WIDTH-FRAC-1:0] shr;
    logic [PREC-1:0] res_s, res, gsat, out_q, grad_q;
    logic acc_ovf, prec_ovf, stk, sticky, sat_q;
    assign w        = weight_i[g*PREC +: PREC];
    assign b        = bias_i[g*PREC +: PREC];
    assign prod     = (2*PREC)'(w) * (2*PREC)'($signed(activation_i));
    assign base     = first ? (bias_en_i ? (ACC_WIDTH+1)'(b) <<< FRAC : '0) : (ACC_WIDTH+1)'(acc);
    assign sum      = base + (ACC_WIDTH+1)'(prod);
    assign acc_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign acc_sat  = acc_ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
    assign shr      = acc_sat[ACC_WIDTH-1:FRAC];
    assign prec_ovf = !(&shr[ACC_WIDTH-FRAC-1:PREC-1]) && |shr[ACC_WIDTH-FRAC-1:PREC-1];
    assign res_s    = prec_ovf ? {shr[ACC_WIDTH-FRAC-1], {(PREC-1){~shr[ACC_WIDTH-FRAC-1]}}} : shr[PREC-1:0];
`ifdef FC_RELU_EN
    assign res      = shr[ACC_WIDTH-FRAC-1] ? '0 : res_s;
`else
    assign res      = res_s;
`endif
    assign stk      = (!first && sticky) || acc_ovf;
    assign gshr     = bp_mode ? prod >>> (FRAC + BP_SHIFT) : prod >>> FRAC;
    assign gsat     = (!(&gshr[2*PREC-1:PREC-1]) && |gshr[2*PREC-1:PREC-1]) ?
                      {gshr[2*PREC-1], {(PREC-1){~gshr[2*PREC-1]}}} : gshr[PREC-1:0];
    // lane accumulator, sticky saturation flag, result and gradient registers
    always_ff @(posedge clk)
      if (!rst) begin
        acc    <= '0;
        sticky <= 1'b0;
        out_q  <= '0;
        sat_q  <= 1'b0;
        grad_q <= '0;
      end else begin
        grad_q <= gsat;
        if (clear_i) begin
          acc    <= '0;
          sticky <= 1'b0;
        end else if (acc_en) begin
          acc    <= last ? '0 : acc_sat;
          sticky <= last ? 1'b0 : stk;
        end
        if (acc_en && last) begin
          out_q <= res;
          sat_q <= stk || prec_ovf;
        end
      end
    assign activation_o[g*PREC +: PREC] = out_q;
    assign b_gradient_o[g*PREC +: PREC] = grad_q;
    assign sat_o[g]                     = sat_q;
  end
endmodule

// File: tb/tb_fc_mac_array.sv
// tb_fc_mac_array: directed self-checking bench for fc_mac_array at FAN_IN=4, four lanes
module tb_fc_mac_array;
  localparam int PREC = 18;
  localparam int NL   = 4;
  localparam int IDW  = 10;
  localparam int W    = NL * PREC;
  localparam logic [W-1:0] W0 = {18'h00000, 18'h3C000, 18'h08000, 18'h04000};
  localparam logic [W-1:0] B0 = {18'h01000, 18'h01000, 18'h00000, 18'h01000};
  localparam logic [W-1:0] W1 = {54'h0, 18'h04000};
  localparam logic [W-1:0] B_EXP = {54'h0, 18'h10000};
`ifdef FC_RELU_EN
  localparam logic [W-1:0] DOT_EXP   = {18'h01000, 18'h00000, 18'h10000, 18'h09000};
  localparam logic [W-1:0] SAT2_EXP  = {54'h0, 18'h00000};
  localparam logic [W-1:0] FLOOR_EXP = {54'h0, 18'h00000};
  localparam logic [W-1:0] NEG_EXP   = {54'h0, 18'h00000};
`else
  localparam logic [W-1:0] DOT_EXP   = {18'h01000, 18'h39000, 18'h10000, 18'h09000};
  localparam logic [W-1:0] SAT2_EXP  = {54'h0, 18'h20000};
  localparam logic [W-1:0] FLOOR_EXP = {54'h0, 18'h3FFFF};
  localparam logic [W-1:0] NEG_EXP   = {54'h0, 18'h3C000};
`endif
  logic clk = 1'b0;
  logic rst;
  logic [PREC-1:0] activation_i;
  logic [W-1:0] weight_i, bias_i, activation_o, b_gradient_o;
  logic bias_en_i, valid_i, ready_o, clear_i, valid_o, ready_i, b_valid_i, bp_mode, b_valid_o;
  logic [IDW-1:0] neuron_id_i, neuron_id_o;
  logic [NL-1:0] sat_o;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fc_mac_array #(.PREC(PREC), .FRAC(14), .FAN_IN(4), .NUM_LANES(NL), .ID_WIDTH(IDW),
                 .ACC_WIDTH(40), .BP_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .activation_i(activation_i), .weight_i(weight_i), .bias_i(bias_i),
    .bias_en_i(bias_en_i), .neuron_id_i(neuron_id_i), .valid_i(valid_i), .ready_o(ready_o),
    .clear_i(clear_i), .activation_o(activation_o), .neuron_id_o(neuron_id_o), .valid_o(valid_o),
    .ready_i(ready_i), .sat_o(sat_o), .b_valid_i(b_valid_i), .bp_mode(bp_mode),
    .b_gradient_o(b_gradient_o), .b_valid_o(b_valid_o)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [PREC-1:0] a, input logic [W-1:0] w, input logic [W-1:0] b,
                      input logic be, input logic [IDW-1:0] id, input logic v);
    activation_i = a;
    weight_i     = w;
    bias_i       = b;
    bias_en_i    = be;
    neuron_id_i  = id;
    valid_i      = v;
    tick();
  endtask
  task automatic send(input logic [PREC-1:0] a, input logic [W-1:0] w, input logic [W-1:0] b,
                      input logic be, input logic [IDW-1:0] id);
    for (int i = 0; i < 4; i++) beat(a, w, i == 0 ? b : ~b, be, id, 1'b1);
    valid_i = 1'b0;
  endtask
  initial begin
    rst = 1'b0; activation_i = 18'h1FFFF; weight_i = W0; bias_i = B0; bias_en_i = 1'b1;
    neuron_id_i = 10'h3FF; valid_i = 1'b1; ready_i = 1'b1; clear_i = 1'b0;
    b_valid_i = 1'b1; bp_mode = 1'b0;
    tick(); tick();
    check("rst_act", activation_o, '0);
    check("rst_id", W'(neuron_id_o), '0);
    check("rst_valid", W'(valid_o), '0);
    check("rst_sat", W'(sat_o), '0);
    check("rst_bvalid", W'(b_valid_o), '0);
    check("rst_grad", b_gradient_o, '0);
    check("rst_ready", W'(ready_o), W'(1));
    rst = 1'b1; valid_i = 1'b0; b_valid_i = 1'b0;
    send(18'h02000, W0, B0, 1'b1, 10'h155);
    check("dot_act", activation_o, DOT_EXP);
    check("dot_id", W'(neuron_id_o), W'(10'h155));
    check("dot_valid", W'(valid_o), W'(1));
    check("dot_sat", W'(sat_o), '0);
    tick();
    check("dot_drain_valid", W'(valid_o), '0);
    check("dot_drain_hold", activation_o, DOT_EXP);
    send(18'h1FFFF, {4{18'h1FFFF}}, B0, 1'b0, 10'h001);
    check("satp_act", activation_o, {4{18'h1FFFF}});
    check("satp_sat", W'(sat_o), W'(4'hF));
    send(18'h1FFFF, {54'h0, 18'h20000}, B0, 1'b0, 10'h002);
    check("satn_act", activation_o, SAT2_EXP);
    check("satn_sat", W'(sat_o), W'(4'h1));
    send(18'h3FFFF, {54'h0, 18'h00001}, B0, 1'b0, 10'h003);
    check("floor_act", activation_o, FLOOR_EXP);
    check("floor_sat", W'(sat_o), '0);
    send(18'h3F000, {54'h0, 18'h04000}, B0, 1'b0, 10'h004);
    check("neg_act", activation_o, NEG_EXP);
    beat(18'h1FFFF, W0, B0, 1'b1, 10'h000, 1'b1);
    beat(18'h1FFFF, W0, B0, 1'b1, 10'h000, 1'b1);
    clear_i = 1'b1;
    beat(18'h1FFFF, W0, B0, 1'b1, 10'h000, 1'b1);
    clear_i = 1'b0;
    check("clr_out_kept", activation_o, NEG_EXP);
    check("clr_valid_low", W'(valid_o), '0);
    send(18'h02000, W0, B0, 1'b1, 10'h2AA);
    check("clr_fresh_act", activation_o, DOT_EXP);
    check("clr_fresh_id", W'(neuron_id_o), W'(10'h2AA));
    ready_i = 1'b0; clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_hold_valid", W'(valid_o), W'(1));
    check("clr_hold_act", activation_o, DOT_EXP);
    ready_i = 1'b1;
    beat(18'h04000, W1, B0, 1'b0, 10'h0B0, 1'b1);
    ready_i = 1'b0;
    #1;
    check("bp_ready_open", W'(ready_o), W'(1));
    for (int i = 1; i < 4; i++) beat(18'h04000, W1, ~B0, 1'b0, 10'h0B0, 1'b1);
    check("bp_b_act", activation_o, B_EXP);
    check("bp_b_id", W'(neuron_id_o), W'(10'h0B0));
    check("bp_ready_drop", W'(ready_o), '0);
    for (int i = 0; i < 3; i++) begin
      beat(18'h02000, W0, B0, 1'b1, 10'h0C0, 1'b1);
      check("bp_stall_act", activation_o, B_EXP);
      check("bp_stall_valid", W'(valid_o), W'(1));
    end
    ready_i = 1'b1;
    send(18'h02000, W0, B0, 1'b1, 10'h0C0);
    check("bp_c_act", activation_o, DOT_EXP);
    check("bp_c_id", W'(neuron_id_o), W'(10'h0C0));
    for (int i = 0; i < 4; i++) begin
      beat(18'h02000, W0, i == 0 ? B0 : ~B0, 1'b1, 10'h111, 1'b1);
      if (i < 3) beat(18'h1FFFF, {4{18'h1FFFF}}, ~B0, 1'b1, 10'h000, 1'b0);
      if (i == 1) check("gap_valid_low", W'(valid_o), '0);
    end
    check("gap_act", activation_o, DOT_EXP);
    check("gap_id", W'(neuron_id_o), W'(10'h111));
    activation_i = 18'h02000; weight_i = {18'h20000, 18'h1FFFF, 18'h3C000, 18'h04000};
    b_valid_i = 1'b1; bp_mode = 1'b0;
    tick();
    check("grad_w_val", b_gradient_o, {18'h30000, 18'h0FFFF, 18'h3E000, 18'h02000});
    check("grad_bvalid", W'(b_valid_o), W'(1));
    bp_mode = 1'b1;
    tick();
    check("grad_n_val", b_gradient_o, {18'h3F800, 18'h007FF, 18'h3FF00, 18'h00100});
    b_valid_i = 1'b0; bp_mode = 1'b0;
    activation_i = 18'h1FFFF; weight_i = {18'h20000, 36'h0, 18'h1FFFF};
    tick();
    check("grad_sat_val", b_gradient_o, {18'h20000, 36'h0, 18'h1FFFF});
    check("grad_bvalid_low", W'(b_valid_o), '0);
    beat(18'h1FFFF, W0, B0, 1'b1, 10'h000, 1'b1);
    beat(18'h1FFFF, W0, B0, 1'b1, 10'h000, 1'b1);
    b_valid_i = 1'b1; rst = 1'b0; valid_i = 1'b0;
    tick();
    check("rst2_act", activation_o, '0);
    check("rst2_id", W'(neuron_id_o), '0);
    check("rst2_valid", W'(valid_o), '0);
    check("rst2_bvalid", W'(b_valid_o), '0);
    check("rst2_grad", b_gradient_o, '0);
    rst = 1'b1; b_valid_i = 1'b0;
    send(18'h02000, W0, B0, 1'b1, 10'h3C3);
    check("rst2_dot_act", activation_o, DOT_EXP);
    check("rst2_dot_id", W'(neuron_id_o), W'(10'h3C3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_mac_array.md
Name: fc_mac_array

Overview:
Multi-lane, parametrised successor to the single-neuron FC kernel. NUM_LANES neurons share one activation stream, and each lane accumulates a FAN_IN-long signed fixed-point dot product with bias. Each lane saturates its accumulator and then saturates its PREC-wide result. The block adds valid/ready flow control on both sides, a mid-vector abort, and a per-lane backprop gradient path with a selectable shift. It sits between the activation buffer and the next layer's input FIFO.

Parameters:
- PREC, 18: data width (signed Q format).
- FRAC, 14: fractional bits of activations, weights and bias.
- FAN_IN, 784: beats per output vector; must be >= 1.
- NUM_LANES, 4: parallel neurons.
- ID_WIDTH, 10: neuron-group id width.
- ACC_WIDTH, 40: accumulator width; must be >= 2*PREC.
- BP_SHIFT, 5: extra right shift applied to the gradient in neuron mode.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-low.
- activation_i, input, PREC: shared activation for the current beat.
- weight_i, input, NUM_LANES*PREC: per-lane weights; lane k is in bits [k*PREC +: PREC].
- bias_i, input, NUM_LANES*PREC: per-lane bias, sampled on beat 0.
- bias_en_i, input, 1: add bias on beat 0.
- neuron_id_i, input, ID_WIDTH: group id, captured on the last beat.
- valid_i, input, 1: input beat valid.
- ready_o, output, 1: input beat accepted when valid_i && ready_o.
- clear_i, input, 1: abort the partial vector.
- activation_o, output, NUM_LANES*PREC: lane results.
- neuron_id_o, output, ID_WIDTH: id of the current result.
- valid_o, output, 1: result valid.
- ready_i, input, 1: downstream accept.
- sat_o, output, NUM_LANES: per-lane flag; a saturation occurred in this result.
- b_valid_i, input, 1: gradient request.
- bp_mode, input, 1: 0 = weight mode, 1 = neuron mode.
- b_gradient_o, output, NUM_LANES*PREC: per-lane gradient.
- b_valid_o, output, 1: gradient valid.

Behaviour:
- Reset (rst low at a clk edge):
  - cnt = 0, every acc = 0.
  - valid_o = 0, activation_o = 0, neuron_id_o = 0, sat_o = 0.
  - b_valid_o = 0, b_gradient_o = 0.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - Output register holds activation_o, neuron_id_o and sat_o stable while valid_o && !ready_i.
  - valid_o clears on a handshake unless a new last beat is accepted in the same cycle.
- Beat counter:
  - cnt (clog2(FAN_IN) bits) increments on each accepted beat and wraps FAN_IN-1 -> 0.
  - Gaps in valid_i hold cnt and acc; a partial vector is never lost.
- Per-lane arithmetic on an accepted beat:
  - prod = signed weight * signed activation, 2*PREC bits with 2*FRAC fractional bits.
  - base = (cnt == 0) ? (bias_en_i ? sign-extended bias << FRAC : 0) : acc.
  - sum = base + sign-extended prod, computed one bit wider than ACC_WIDTH, then saturated to the ACC_WIDTH signed range.
- Non-last beat: acc <= saturated sum.
- Last beat (cnt == FAN_IN-1):
  - activation_o lane <= saturate_PREC(sum >>> FRAC), truncating toward -inf.
  - neuron_id_o <= neuron_id_i; valid_o <= 1.
  - sat_o lane <= 1 if either the ACC_WIDTH saturation or the PREC saturation fired on any beat of this vector (tracked by a sticky per-lane flag that is cleared on beat 0).
  - acc <= 0.
- Latency: last beat accepted at cycle t -> valid_o high at t+1.
- FAN_IN = 1: every beat is both first and last.
- clear_i:
  - Sets cnt = 0 and every acc = 0, and clears the sticky flags.
  - Does not touch the output register.
  - If clear_i and an accepted beat coincide, clear wins and the beat is discarded.
- Gradient path (independent of ready/valid; one-cycle latency):
  - b_valid_o <= b_valid_i.
  - b_gradient_o lane <= saturate_PREC(prod >>> (FRAC + (bp_mode ? BP_SHIFT : 0))).
  - Registered every cycle regardless of b_valid_i.
- Saturation limits:
  - Maximum = 2^(PREC-1)-1 (0x1FFFF at PREC = 18).
  - Minimum = -2^(PREC-1) (0x20000).

Optional Feature:
Macro FC_RELU_EN.
- Defined: on the last beat, a negative result is written as 0 to activation_o. sat_o is still set by negative saturation. The gradient path is unchanged.
- Undefined: signed results pass through unchanged.

Test Plan:
All scenarios use PREC=18, FRAC=14, FAN_IN=4, NUM_LANES=4.
- Dot product: lane0 w=0x04000 for 4 beats, act=0x02000, bias=0x01000, bias_en_i=1 -> activation_o lane0 = 0x09000 one cycle after the 4th beat; neuron_id_o = id on beat 3; sat_o = 0.
- Saturation: w=0x1FFFF, act=0x1FFFF, 4 beats -> 0x1FFFF with sat_o[0]=1. w=0x20000, act=0x1FFFF -> 0x20000 with sat_o[0]=1.
- Backpressure: ready_i held 0 after the first result, with valid_i continuous -> ready_o drops after the next 4 beats are accepted, the output holds, and no beat is lost. Releasing ready_i yields the second vector's result.
- Gaps and abort: valid_i toggled every other cycle gives the same 0x09000. clear_i after 2 beats, then 4 fresh beats -> result reflects only the fresh beats. A beat coincident with clear_i is ignored.
- Gradient: w=0x04000, act=0x02000, b_valid_i=1 -> bp_mode=0 gives 0x02000; bp_mode=1 gives 0x00100; b_valid_o one cycle later.
- Reset and ReLU: rst low mid-vector -> all outputs 0 and cnt restarts. With FC_RELU_EN, a vector summing to -1.0 gives 0x00000.
